// File: rtl/fetch_pc_gen_if.sv
// Fetch-stage control and PC bus between the pipeline front end and the PC generator.
// The master drives the stall/redirect controls; the slave returns the PC, its successor and debug state.
interface fetch_pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_stall;
  logic            i_b_taken;
  logic [XLEN-1:0] i_b_pc;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_pc_plus4;
  logic [XLEN-1:0] o_pc_next;
  logic [XLEN-1:0] o_counter;
  logic            o_misaligned;

  modport master (
    output i_stall, i_b_taken, i_b_pc,
    input  o_pc, o_pc_plus4, o_pc_next, o_counter, o_misaligned
  );

  modport slave (
    input  i_stall, i_b_taken, i_b_pc,
    output o_pc, o_pc_plus4, o_pc_next, o_counter, o_misaligned
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// RV32 stage-1 next-PC generator: the fetch PC register, a sequential adder and a redirect mux.
// Also keeps a count of PC updates and flags redirects to targets that are not word-aligned.
module fetch_pc_gen #(
  parameter int unsigned           XLEN     = 32,
  parameter logic [XLEN-1:0]       RESET_PC = '0,
  parameter int unsigned           PC_STEP  = 4
) (
  input logic           i_clk,
  input logic           i_rst_n,
  fetch_pc_gen_if.slave bus
);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_counter;
  logic            r_misaligned;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_next;
  logic            w_update;
  logic            w_misaligned;

  assign w_pc_plus4 = r_pc + STEP;

  // Redirect wins over stall, so a branch resolved during a stall is never lost.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (bus.i_b_taken) begin
      w_pc_next = {bus.i_b_pc[XLEN-1:2], 2'b00};
    end else if (bus.i_stall) begin
      w_pc_next = r_pc;
    end
  end

  assign w_update     = bus.i_b_taken | ~bus.i_stall;
  assign w_misaligned = bus.i_b_taken & (bus.i_b_pc[1:0] != 2'b00);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc         <= RESET_PC;
      r_counter    <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_pc         <= w_pc_next;
      r_misaligned <= w_misaligned;
      if (w_update) begin
        r_counter <= r_counter + 1'b1;
      end
    end
  end

  assign bus.o_pc         = r_pc;
  assign bus.o_pc_plus4   = w_pc_plus4;
  assign bus.o_pc_next    = w_pc_next;
  assign bus.o_counter    = r_counter;
  assign bus.o_misaligned = r_misaligned;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed vector bench for fetch_pc_gen: a table of per-cycle stimulus with hand-computed
// pre-edge combinational and post-edge registered values, plus an asynchronous-reset sequence.
module tb_fetch_pc_gen;
  logic i_clk;
  logic i_rst_n;

  fetch_pc_gen_if #(.XLEN(32)) bus ();

  fetch_pc_gen #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        stall;
    logic        taken;
    logic [31:0] b_pc;
    logic [31:0] exp_next;
    logic [31:0] exp_plus4;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [14];
  int   total;
  int   bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //          stall taken b_pc          next          plus4         pc            cnt  mis
    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h4,        32'h4,        32'h4,        32'd1,  1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h8,        32'h8,        32'h8,        32'd2,  1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'hC,        32'hC,        32'hC,        32'd3,  1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h100,      32'h100,      32'h10,       32'h100,      32'd4,  1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        32'h104,      32'h104,      32'h104,      32'd5,  1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        32'h104,      32'h108,      32'h104,      32'd5,  1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,        32'h104,      32'h108,      32'h104,      32'd5,  1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h200,      32'h200,      32'h108,      32'h200,      32'd6,  1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h203,      32'h200,      32'h204,      32'h200,      32'd7,  1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        32'h204,      32'h204,      32'h204,      32'd8,  1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h208,     32'hFFFF_FFFC, 32'd9,  1'b1};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        32'd10, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h55,       32'h0,        32'h4,        32'h0,        32'd10, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 32'h1236,     32'h1234,     32'h4,        32'h1234,     32'd11, 1'b1};

    bus.i_stall   = 1'b0;
    bus.i_b_taken = 1'b0;
    bus.i_b_pc    = '0;
    i_rst_n       = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_pc",    bus.o_pc,       32'h0);
    chk("reset_cnt",   bus.o_counter,  32'h0);
    chk("reset_mis",   {31'b0, bus.o_misaligned}, 32'h0);
    chk("reset_plus4", bus.o_pc_plus4, 32'h4);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      bus.i_stall   = vecs[i].stall;
      bus.i_b_taken = vecs[i].taken;
      bus.i_b_pc    = vecs[i].b_pc;
      #1;
      chk($sformatf("v%0d_next", i),  bus.o_pc_next,  vecs[i].exp_next);
      chk($sformatf("v%0d_plus4", i), bus.o_pc_plus4, vecs[i].exp_plus4);
      @(posedge i_clk);
      #1;
      chk($sformatf("v%0d_pc", i),  bus.o_pc,      vecs[i].exp_pc);
      chk($sformatf("v%0d_cnt", i), bus.o_counter, vecs[i].exp_cnt);
      chk($sformatf("v%0d_mis", i), {31'b0, bus.o_misaligned}, {31'b0, vecs[i].exp_mis});
      @(negedge i_clk);
    end

    // Asynchronous reset between edges with a misaligned redirect just taken and another pending.
    bus.i_stall   = 1'b0;
    bus.i_b_taken = 1'b1;
    bus.i_b_pc    = 32'h800;
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_pc",  bus.o_pc,      32'h0);
    chk("async_cnt", bus.o_counter, 32'h0);
    chk("async_mis", {31'b0, bus.o_misaligned}, 32'h0);
    @(posedge i_clk);
    #1;
    chk("hold_pc",  bus.o_pc,      32'h0);
    chk("hold_cnt", bus.o_counter, 32'h0);
    @(negedge i_clk);
    bus.i_b_taken = 1'b0;
    bus.i_b_pc    = '0;
    i_rst_n       = 1'b1;
    @(posedge i_clk);
    #1;
    chk("release_pc",  bus.o_pc,      32'h4);
    chk("release_cnt", bus.o_counter, 32'h1);
    chk("release_mis", {31'b0, bus.o_misaligned}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end
endmodule
